iecdrv_fastser: RTL and testbench

- Parametrised fast-serial (burst) engine for the drive models. It replaces the bare 6526 SP/CNT path used for 1570/1571 burst transfers.
- Adds TX and RX FIFOs, a programmable bit clock, configurable word width, overrun detection and a per-word completion strobe.
- Sits between the drive CPU bus glue and the IEC SRQ (fast clock) and DATA lines.
- Lets custom ROMs and future models (1571CR, 1581-class) stream bursts without servicing an interrupt per byte.

---
 rtl/iecdrv_fastser_pkg.sv | 7 +
 rtl/iecdrv_fifo.sv | 44 ++++
 rtl/iecdrv_fastser.sv | 136 +++++++++++++
 tb/tb_iecdrv_fastser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iecdrv_fastser_pkg.sv
// iecdrv_fastser_pkg: shared state encoding and sizing helper for the fast-serial engine
package iecdrv_fastser_pkg;
  typedef enum logic [1:0] {IDLE, TX_LO, TX_HI, RX} state_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/iecdrv_fifo.sv
// iecdrv_fifo: synchronous first-word-fall-through FIFO with occupancy level and flush
module iecdrv_fifo import iecdrv_fastser_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      clr,
  input  logic                      wr,
  input  logic [WIDTH-1:0]          din,
  input  logic                      rd,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_rd, do_wr;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_rd = rd & ~empty;
  // a pop in the same clk frees the slot, so a push into a full FIFO still lands
  assign do_wr = wr & (~full | do_rd);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_wr && !clr) mem[wp] <= din;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_wr ? wp + AW'(1) : wp;
      rp <= do_rd ? rp + AW'(1) : rp;
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
endmodule

// File: rtl/iecdrv_fastser.sv
// iecdrv_fastser: FIFO-buffered fast-serial burst engine driving SRQ/DATA for the drive models
module iecdrv_fastser import iecdrv_fastser_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     ce,
  input  logic                     dir,
  input  logic [DIV_W-1:0]         div,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_wr,
  output logic                     tx_full,
  output logic [lvl_w(DEPTH)-1:0]  tx_level,
  output logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_rd,
  output logic                     rx_empty,
  output logic [lvl_w(DEPTH)-1:0]  rx_level,
  input  logic                     sp_in,
  input  logic                     cnt_in,
  output logic                     sp_out,
  output logic                     cnt_out,
  output logic                     busy,
  output logic                     ovr,
  output logic                     done
);
  localparam int BW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n, tx_head;
  logic [BW-1:0] bc, bc_n;
  logic [DIV_W-1:0] dc, dc_n;
  logic busy_n, done_n, dir_q, tx_pop, rx_push, tx_empty, rx_full;
  logic c1, c2, c3, s1, s2, rise;
  assign rise = c2 & ~c3;
  assign cnt_out = state != TX_LO;
  assign sp_out = (state == TX_LO || state == TX_HI) ? sh[WIDTH-1] : 1'b1;
  iecdrv_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .res_n(res_n), .clr(clr), .wr(tx_wr & ~tx_full), .din(tx_data), .rd(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );
  iecdrv_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .res_n(res_n), .clr(clr), .wr(rx_push), .din(sh_n), .rd(rx_rd),
    .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );
  always_comb begin
    state_n = state;
    sh_n = sh;
    bc_n = bc;
    dc_n = dc;
    busy_n = busy;
    done_n = 1'b0;
    tx_pop = 1'b0;
    rx_push = 1'b0;
    if (dir != dir_q) begin
      state_n = IDLE;
      sh_n = '0;
      bc_n = '0;
      busy_n = 1'b0;
    end else begin
      case (state)
        IDLE:
          if (dir && !tx_empty) begin
            tx_pop = 1'b1;
            sh_n = tx_head;
            bc_n = BW'(WIDTH);
            dc_n = div;
            busy_n = 1'b1;
            state_n = TX_LO;
          end else if (!dir) begin
            bc_n = '0;
            state_n = RX;
          end
        TX_LO:
          if (ce) begin
            dc_n = dc == '0 ? div : dc - DIV_W'(1);
            state_n = dc == '0 ? TX_HI : TX_LO;
          end
        TX_HI:
          if (ce && dc == '0) begin
            dc_n = div;
            sh_n = sh << 1;
            bc_n = bc - BW'(1);
            state_n = bc == BW'(1) ? IDLE : TX_LO;
            done_n = bc == BW'(1);
            busy_n = bc != BW'(1);
          end else if (ce) begin
            dc_n = dc - DIV_W'(1);
          end
        RX:
          if (rise) begin
            sh_n = {sh[WIDTH-2:0], s2};
            rx_push = bc == BW'(WIDTH - 1);
            bc_n = rx_push ? '0 : bc + BW'(1);
            busy_n = ~rx_push;
            done_n = rx_push;
          end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state <= IDLE;
      sh <= '0;
      bc <= '0;
      dc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ovr <= 1'b0;
      dir_q <= 1'b0;
      {c1, c2, c3, s1, s2} <= '1;
    end else begin
      {c1, c2, c3} <= {cnt_in, c1, c2};
      {s1, s2} <= {sp_in, s1};
      dir_q <= dir;
      if (clr) begin
        state <= IDLE;
        sh <= '0;
        bc <= '0;
        dc <= '0;
        busy <= 1'b0;
        done <= 1'b0;
        ovr <= 1'b0;
      end else begin
        state <= state_n;
        sh <= sh_n;
        bc <= bc_n;
        dc <= dc_n;
        busy <= busy_n;
        done <= done_n;
        ovr <= ovr | (rx_push & rx_full & ~rx_rd);
      end
    end
endmodule

// File: tb/tb_iecdrv_fastser.sv
// tb_iecdrv_fastser: directed table-driven and sequence checks of the fast-serial engine
module tb_iecdrv_fastser;
  logic clk = 1'b0, res_n = 1'b0, ce = 1'b1, dir = 1'b0, clr = 1'b0;
  logic [7:0] div = 8'd1, tx_data = '0, rx_data;
  logic tx_wr = 1'b0, rx_rd = 1'b0, sp_in = 1'b1, cnt_in = 1'b1;
  logic tx_full, rx_empty, sp_out, cnt_out, busy, ovr, done;
  logic [2:0] tx_level, rx_level;
  int ncmp = 0, nerr = 0, dcount = 0;

  typedef struct { logic [7:0] w; logic [7:0] d; int lat; int lows; } txv_t;
  txv_t tv[5];

  iecdrv_fastser dut (
    .clk(clk), .res_n(res_n), .ce(ce), .dir(dir), .div(div), .clr(clr),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_level(tx_level),
    .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_level(rx_level),
    .sp_in(sp_in), .cnt_in(cnt_in), .sp_out(sp_out), .cnt_out(cnt_out),
    .busy(busy), .ovr(ovr), .done(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (res_n && done) dcount++;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] e);
    chk(nm, rx_data, e);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] w, input bit rd);
    for (int b = 7; b >= 0; b--) begin
      @(negedge clk);
      cnt_in = 1'b0;
      sp_in = w[b];
      repeat (3) @(negedge clk);
      cnt_in = 1'b1;
      repeat (2) @(negedge clk);
      if (rd && b == 0) rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
  endtask

  task automatic run_tx(input logic [7:0] w, input logic [7:0] d, output logic [7:0] bits,
                        output int lat, output int lows, output int rises);
    logic pc;
    bits = '0;
    lat = -1;
    lows = 0;
    rises = 0;
    pc = 1'b1;
    div = d;
    push(w);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (!cnt_out) lows++;
      if (!pc && cnt_out) begin
        bits = {bits[6:0], sp_out};
        rises++;
      end
      pc = cnt_out;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] bits, rxw[16];
    logic [31:0] stream;
    int lat, lows, rises, nd, idle, d0;
    bit started, pc;
    tv[0] = '{8'hA5, 8'd1, 33, 16};
    tv[1] = '{8'h00, 8'd0, 17, 8};
    tv[2] = '{8'hFF, 8'd2, 49, 24};
    tv[3] = '{8'h3C, 8'd0, 17, 8};
    tv[4] = '{8'h81, 8'd3, 65, 32};
    for (int i = 0; i < 16; i++) rxw[i] = 8'(i * 29 + 3);

    #12;
    chk("rst_sp_out", sp_out, 1);
    chk("rst_cnt_out", cnt_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_empty", rx_empty, 1);
    @(negedge clk);
    res_n = 1'b1;
    dir = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_tx(tv[i].w, tv[i].d, bits, lat, lows, rises);
      chk($sformatf("tx%0d_bits", i), bits, tv[i].w);
      chk($sformatf("tx%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("tx%0d_low_ticks", i), lows, tv[i].lows);
      chk($sformatf("tx%0d_rises", i), rises, 8);
      chk($sformatf("tx%0d_released", i), {sp_out, cnt_out, busy}, 3'b110);
    end

    // back-to-back: fill while in RX so nothing drains, then turn around
    dir = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("b2b_full", tx_full, 1);
    push(8'h05);
    chk("b2b_level_after_5th", tx_level, 4);
    div = 8'd0;
    dir = 1'b1;
    stream = '0;
    nd = 0;
    idle = 0;
    started = 1'b0;
    pc = 1'b1;
    d0 = dcount;
    for (int n = 0; n < 300 && nd < 4; n++) begin
      @(negedge clk);
      if (busy) started = 1'b1;
      if (started && !busy) idle++;
      if (!pc && cnt_out) stream = {stream[30:0], sp_out};
      pc = cnt_out;
      if (done) nd++;
    end
    chk("b2b_dones", nd, 4);
    chk("b2b_stream", stream, 32'h01020304);
    chk("b2b_idle_clks", idle, 4);
    repeat (20) @(negedge clk);
    chk("b2b_no_5th_word", dcount - d0, 4);
    chk("b2b_tx_level", tx_level, 0);

    // RX overrun run
    dir = 1'b0;
    repeat (3) @(negedge clk);
    d0 = dcount;
    for (int i = 0; i < 16; i++) begin
      send_rx(rxw[i], 1'b0);
      if (i == 3) chk("rx_ovr_before_5th", ovr, 0);
      if (i == 4) chk("rx_ovr_after_5th", ovr, 1);
    end
    @(negedge clk);
    chk("rx_done_pulses", dcount - d0, 16);
    chk("rx_level_full", rx_level, 4);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rx_word%0d", i), rxw[i]);
    chk("rx_empty_after_reads", rx_empty, 1);
    send_rx(8'h3E, 1'b0);
    send_rx(8'hC1, 1'b0);
    chk("rx_level_refill", rx_level, 2);
    chk("rx_ovr_sticky", ovr, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ovr", ovr, 0);
    chk("clr_rx_empty", rx_empty, 1);
    chk("clr_rx_level", rx_level, 0);

    // RX push into a full FIFO coinciding with a pop
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) send_rx(8'(8'h10 + i), 1'b0);
    chk("sim_level_pre", rx_level, 4);
    send_rx(8'h99, 1'b1);
    chk("sim_ovr", ovr, 0);
    chk("sim_level", rx_level, 4);
    rd_chk("sim_word0", 8'h11);
    rd_chk("sim_word1", 8'h12);
    rd_chk("sim_word2", 8'h13);
    rd_chk("sim_word3", 8'h99);

    // abort mid-word on a direction change
    push(8'hFF);
    push(8'h11);
    push(8'h22);
    chk("abort_level_pre", tx_level, 3);
    div = 8'd1;
    dir = 1'b1;
    rises = 0;
    pc = 1'b1;
    for (int n = 0; n < 200 && rises < 3; n++) begin
      @(negedge clk);
      if (!pc && cnt_out) rises++;
      pc = cnt_out;
    end
    repeat (2) @(negedge clk);
    chk("abort_mid_low", {cnt_out, busy}, 2'b01);
    d0 = dcount;
    dir = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_outputs", {sp_out, cnt_out}, 2'b11);
    chk("abort_tx_level", tx_level, 2);
    repeat (20) @(negedge clk);
    chk("abort_no_done", dcount - d0, 0);

    // asynchronous reset in the middle of TX_LO
    dir = 1'b1;
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!cnt_out) begin
        lat = n;
        break;
      end
    end
    chk("areset_reached_tx_lo", lat >= 0, 1);
    chk("areset_pre_sp", sp_out, 0);
    #2 res_n = 1'b0;
    #1;
    chk("areset_outputs", {sp_out, cnt_out}, 2'b11);
    chk("areset_busy", busy, 0);
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    chk("areset_tx_level", tx_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
